// File: rtl/aim_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : aim_pkg                                                 |
// | Purpose  : Shared types, widths and the saturating clamp used by   |
// |            the aim point predictor.                                |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package aim_pkg;

    localparam int COORD_W = 16;
    localparam int VEL_W   = 17;
    // Wide enough for coord + (vel <<< 4) with sign, so no intermediate wrap.
    localparam int SUM_W   = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_e;

    // Clamp a signed projected coordinate into the unsigned coordinate range.
    function automatic logic [COORD_W-1:0] sat_clamp(input logic signed [SUM_W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > $signed(SUM_W'(65535)))
            return '1;
        else
            return v[COORD_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lead_axis_calc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : lead_axis_calc                                          |
// | Purpose  : Per-axis velocity, saturated lead aim point and the     |
// |            velocity-consistency flag (combinational).              |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module lead_axis_calc
    import aim_pkg::*;
#(
    parameter int          LEAD_SHIFT = 2,
    parameter logic [15:0] VEL_TOL    = 16'd4
) (
    input  logic        [COORD_W-1:0] in_i,
    input  logic        [COORD_W-1:0] prev_i,
    input  logic signed [VEL_W-1:0]   prev_vel_i,
    output logic signed [VEL_W-1:0]   vel_o,
    output logic        [COORD_W-1:0] aim_o,
    output logic                      tol_ok_o
);

    logic signed [SUM_W-1:0] w_vel_ext;
    logic signed [SUM_W-1:0] w_lead;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [17:0]      w_dv;
    logic        [17:0]      w_dv_abs;

    // Velocity, lead projection, clamp and tolerance test.
    always_comb begin
        // Zero-extended 17-bit difference of two 16-bit values cannot overflow.
        vel_o     = $signed({1'b0, in_i}) - $signed({1'b0, prev_i});
        w_vel_ext = {{(SUM_W-VEL_W){vel_o[VEL_W-1]}}, vel_o};
        w_lead    = w_vel_ext <<< LEAD_SHIFT;
        w_sum     = $signed({{(SUM_W-COORD_W){1'b0}}, in_i}) + w_lead;
        aim_o     = sat_clamp(w_sum);
        w_dv      = $signed({vel_o[VEL_W-1], vel_o}) - $signed({prev_vel_i[VEL_W-1], prev_vel_i});
        w_dv_abs  = w_dv[17] ? 18'(-w_dv) : 18'(w_dv);
        tol_ok_o  = (w_dv_abs <= {2'b00, VEL_TOL});
    end

endmodule
`default_nettype wire

// File: rtl/aim_point_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : aim_point_predictor                                     |
// | Purpose  : Lock-tracking FSM, previous sample/velocity registers    |
// |            and single-entry output buffer for lead aim points.     |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module aim_point_predictor
    import aim_pkg::*;
#(
    parameter int          LEAD_SHIFT = 2,
    parameter logic [15:0] VEL_TOL    = 16'd4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic        [COORD_W-1:0] x_in,
    input  logic        [COORD_W-1:0] y_in,
    input  logic                      target_found,
    input  logic                      data_in_valid,
    output logic                      data_in_ready,
    output logic        [COORD_W-1:0] aim_x,
    output logic        [COORD_W-1:0] aim_y,
    output logic signed [VEL_W-1:0]   vel_x,
    output logic signed [VEL_W-1:0]   vel_y,
    output logic                      fire_enable,
    output logic                      data_out_valid,
    input  logic                      data_out_ready
);

    state_e                    state_q, state_d;
    logic        [COORD_W-1:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic signed [VEL_W-1:0]   pvel_x_q, pvel_x_d, pvel_y_q, pvel_y_d;
    logic        [COORD_W-1:0] aim_x_q, aim_x_d, aim_y_q, aim_y_d;
    logic signed [VEL_W-1:0]   vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic                      fire_q, fire_d, valid_q, valid_d;

    logic signed [VEL_W-1:0]   w_vel_x, w_vel_y;
    logic        [COORD_W-1:0] w_aim_x, w_aim_y;
    logic                      w_ok_x, w_ok_y;
    logic                      w_accept;

    lead_axis_calc #(.LEAD_SHIFT(LEAD_SHIFT), .VEL_TOL(VEL_TOL)) u_calc_x (
        .in_i(x_in), .prev_i(prev_x_q), .prev_vel_i(pvel_x_q),
        .vel_o(w_vel_x), .aim_o(w_aim_x), .tol_ok_o(w_ok_x)
    );

    lead_axis_calc #(.LEAD_SHIFT(LEAD_SHIFT), .VEL_TOL(VEL_TOL)) u_calc_y (
        .in_i(y_in), .prev_i(prev_y_q), .prev_vel_i(pvel_y_q),
        .vel_o(w_vel_y), .aim_o(w_aim_y), .tol_ok_o(w_ok_y)
    );

    // Buffer can take a new sample when empty or being drained this cycle.
    assign data_in_ready = ~valid_q | data_out_ready;
    assign w_accept      = data_in_valid & data_in_ready;

    assign aim_x          = aim_x_q;
    assign aim_y          = aim_y_q;
    assign vel_x          = vel_x_q;
    assign vel_y          = vel_y_q;
    assign fire_enable    = fire_q;
    assign data_out_valid = valid_q;

    // Next-state: FSM transitions, reference updates and buffer load/drain.
    always_comb begin
        state_d  = state_q;
        prev_x_d = prev_x_q;
        prev_y_d = prev_y_q;
        pvel_x_d = pvel_x_q;
        pvel_y_d = pvel_y_q;
        aim_x_d  = aim_x_q;
        aim_y_d  = aim_y_q;
        vel_x_d  = vel_x_q;
        vel_y_d  = vel_y_q;
        fire_d   = fire_q;
        valid_d  = valid_q;
        if (w_accept) begin
            valid_d = 1'b1;
            if (!target_found) begin
                state_d = IDLE;
                aim_x_d = x_in;
                aim_y_d = y_in;
                vel_x_d = '0;
                vel_y_d = '0;
                fire_d  = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        prev_x_d = x_in;
                        prev_y_d = y_in;
                        aim_x_d  = x_in;
                        aim_y_d  = y_in;
                        vel_x_d  = '0;
                        vel_y_d  = '0;
                        fire_d   = 1'b0;
                        state_d  = ACQ;
                    end
                    ACQ, TRACK: begin
                        prev_x_d = x_in;
                        prev_y_d = y_in;
                        // Velocity reference follows the newest estimate; on a
                        // mismatch this is the re-baseline.
                        pvel_x_d = w_vel_x;
                        pvel_y_d = w_vel_y;
                        aim_x_d  = w_aim_x;
                        aim_y_d  = w_aim_y;
                        vel_x_d  = w_vel_x;
                        vel_y_d  = w_vel_y;
                        fire_d   = (state_q == TRACK) && w_ok_x && w_ok_y;
                        state_d  = TRACK;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (data_out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State, reference and output buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_x_q <= '0;
            prev_y_q <= '0;
            pvel_x_q <= '0;
            pvel_y_q <= '0;
            aim_x_q  <= '0;
            aim_y_q  <= '0;
            vel_x_q  <= '0;
            vel_y_q  <= '0;
            fire_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_x_q <= prev_x_d;
            prev_y_q <= prev_y_d;
            pvel_x_q <= pvel_x_d;
            pvel_y_q <= pvel_y_d;
            aim_x_q  <= aim_x_d;
            aim_y_q  <= aim_y_d;
            vel_x_q  <= vel_x_d;
            vel_y_q  <= vel_y_d;
            fire_q   <= fire_d;
            valid_q  <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aim_point_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_aim_point_predictor                                  |
// | Purpose  : Scoreboard bench for aim_point_predictor.               |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_aim_point_predictor;

    typedef struct packed {
        logic [15:0] ax;
        logic [15:0] ay;
        logic [16:0] vx;
        logic [16:0] vy;
        logic        f;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] x_in, y_in;
    logic        target_found, data_in_valid, data_in_ready;
    logic [15:0] aim_x, aim_y;
    logic [16:0] vel_x, vel_y;
    logic        fire_enable, data_out_valid, data_out_ready;

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t exp_q[$];

    aim_point_predictor #(.LEAD_SHIFT(2), .VEL_TOL(16'd4)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in),
        .target_found(target_found), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .aim_x(aim_x), .aim_y(aim_y),
        .vel_x(vel_x), .vel_y(vel_y), .fire_enable(fire_enable),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input int ax, input int ay, input int vx, input int vy, input bit f);
        rec_t r;
        r.ax = 16'(ax);
        r.ay = 16'(ay);
        r.vx = 17'(vx);
        r.vy = 17'(vy);
        r.f  = f;
        return r;
    endfunction

    function automatic rec_t dut_rec();
        rec_t r;
        r.ax = aim_x;
        r.ay = aim_y;
        r.vx = vel_x;
        r.vy = vel_y;
        r.f  = fire_enable;
        return r;
    endfunction

    task automatic check_rec(input string name, input rec_t act, input rec_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got aim=(%0d,%0d) vel=(%0d,%0d) fire=%0b, want aim=(%0d,%0d) vel=(%0d,%0d) fire=%0b",
                     name, act.ax, act.ay, $signed(act.vx), $signed(act.vy), act.f,
                     exp.ax, exp.ay, $signed(exp.vx), $signed(exp.vy), exp.f);
        end
    endtask

    task automatic check_bits(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    // Monitor: every drain handshake pops one expected record.
    always @(negedge clk) begin
        if (!reset && data_out_valid && data_out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got aim=(%0d,%0d), want no output", aim_x, aim_y);
            end else begin
                check_rec("output", dut_rec(), exp_q.pop_front());
            end
        end
    end

    // Present one sample; returns #1 after the accepting edge.
    task automatic send(input int x, input int y, input bit f, input rec_t e, input bit push);
        bit acc;
        if (push) exp_q.push_back(e);
        x_in          = 16'(x);
        y_in          = 16'(y);
        target_found  = f;
        data_in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (data_in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        data_in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got data_in_ready=0 for 20 cycles, want 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; x_in = '0; y_in = '0; target_found = 1'b0;
        data_in_valid = 1'b0; data_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_rec("reset_outputs", dut_rec(), mk(0, 0, 0, 0, 0));
        check_bits("reset_handshake", {6'd0, data_out_valid, data_in_ready}, 8'b01);
        @(posedge clk); #1;

        // Basic tracking.
        send(100, 200, 1, mk(100, 200, 0, 0, 0), 1);
        send(110, 205, 1, mk(150, 225, 10, 5, 0), 1);
        send(120, 210, 1, mk(160, 230, 10, 5, 1), 1);
        // Lock loss then reacquire.
        send(130, 215, 0, mk(130, 215, 0, 0, 0), 1);
        send(140, 220, 1, mk(140, 220, 0, 0, 0), 1);
        send(150, 225, 1, mk(190, 245, 10, 5, 0), 1);
        send(160, 230, 1, mk(200, 250, 10, 5, 1), 1);
        // Velocity jump and re-baseline.
        send(190, 235, 1, mk(310, 255, 30, 5, 0), 1);
        send(220, 240, 1, mk(340, 260, 30, 5, 1), 1);

        // Backpressure: buffer holds sample above, new sample waits.
        data_out_ready = 1'b0;
        exp_q.push_back(mk(270, 290, 10, 10, 0));
        x_in = 16'd230; y_in = 16'd250; target_found = 1'b1; data_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bits("bp_ready_low", {6'd0, data_in_ready, data_out_valid}, 8'b01);
            check_rec("bp_hold", dut_rec(), mk(340, 260, 30, 5, 1));
            @(posedge clk); #1;
        end
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        data_in_valid = 1'b0;

        // Load one more into TRACK, then hold it and reset with buffer full.
        send(240, 260, 1, mk(0, 0, 0, 0, 0), 0);
        data_out_ready = 1'b0;
        reset = 1'b1;
        x_in = 16'd500; y_in = 16'd500; target_found = 1'b1; data_in_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; data_in_valid = 1'b0;
        @(negedge clk);
        check_rec("midtrack_reset_outputs", dut_rec(), mk(0, 0, 0, 0, 0));
        check_bits("midtrack_reset_handshake", {6'd0, data_out_valid, data_in_ready}, 8'b01);
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        send(300, 400, 1, mk(300, 400, 0, 0, 0), 1);
        send(310, 405, 1, mk(350, 425, 10, 5, 0), 1);

        // Saturation high.
        send(65000, 100, 0, mk(65000, 100, 0, 0, 0), 1);
        send(65000, 100, 1, mk(65000, 100, 0, 0, 0), 1);
        send(65500, 100, 1, mk(65535, 100, 500, 0, 0), 1);
        // Saturation low.
        send(10, 100, 0, mk(10, 100, 0, 0, 0), 1);
        send(10, 100, 1, mk(10, 100, 0, 0, 0), 1);
        send(2, 100, 1, mk(0, 100, -8, 0, 0), 1);
        // Tolerance boundaries: diff 10 reject, 0 accept, 4 accept, 5 reject.
        send(4, 100, 1, mk(12, 100, 2, 0, 0), 1);
        send(6, 100, 1, mk(14, 100, 2, 0, 1), 1);
        send(12, 100, 1, mk(36, 100, 6, 0, 1), 1);
        send(23, 100, 1, mk(67, 100, 11, 0, 0), 1);

        repeat (4) @(posedge clk);
        #1;
        check_bits("queue_drained", 8'(exp_q.size()), 8'd0);
        check_bits("final_idle_valid", {7'd0, data_out_valid}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
